// File: rtl/fpga_template_pkg.sv
// Shared types and constants for the FPGA template top level: PWM sizing
// defaults and the sys_cfg register fields that feed the PWM block.
package fpga_template_pkg;

    localparam int PWM_N_CH       = 4;
    localparam int PWM_CNT_W      = 8;
    localparam int PWM_PRESCALE_W = 8;

    // One PWM channel's configuration as seen by the register bank
    typedef struct packed {
        logic [PWM_CNT_W-1:0] duty;
        logic [PWM_CNT_W-1:0] phase;
        logic                 polarity;
        logic                 ch_en;
    } pwm_ch_cfg_t;

    // sys_cfg register fields that drive pwm_multi_ch
    typedef struct packed {
        logic                                 enable;
        logic [PWM_PRESCALE_W-1:0]            prescale;
        logic [PWM_CNT_W-1:0]                 period;
        logic                                 update_req;
        pwm_ch_cfg_t [PWM_N_CH-1:0]           ch;
    } rb_sys_cfg_pwm_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: produces a one-clk tick every prescale+1 enabled clocks.
// Held at zero while disabled so a restart always begins a full interval.
module pwm_prescaler
    import fpga_template_pkg::*;
#(
    parameter int PRESCALE_W = PWM_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] psc_cnt;

    assign tick = enable && (psc_cnt == prescale);

    // Count 0..prescale, clearing on the tick and whenever the generator stops
    always_ff @(posedge clk) begin
        if (!resetb) begin
            psc_cnt <= '0;
        end else if (!enable || tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator with programmable period, prescaler, per-channel
// phase, polarity and enable. Config is double-buffered: live inputs are
// copied to the shadow set only at a period wrap (or while stopped), so a
// change never produces a truncated or stretched pulse.
module pwm_multi_ch
    import fpga_template_pkg::*;
#(
    parameter int N_CH       = PWM_N_CH,
    parameter int CNT_W      = PWM_CNT_W,
    parameter int PRESCALE_W = PWM_PRESCALE_W
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [N_CH*CNT_W-1:0]   duty,
    input  logic [N_CH*CNT_W-1:0]   phase,
    input  logic [N_CH-1:0]         polarity,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    update_req,
    output logic                    update_ack,
    output logic                    period_tick,
    output logic [CNT_W-1:0]        cnt_mon,
    output logic [N_CH-1:0]         pwm_out
);

    logic                       tick;
    logic                       wrap;
    logic                       load;
    logic                       pending;
    logic [CNT_W-1:0]           cnt;

    logic [CNT_W-1:0]           sh_period;
    logic [N_CH-1:0][CNT_W-1:0] sh_duty;
    logic [N_CH-1:0][CNT_W-1:0] sh_phase;
    logic [N_CH-1:0]            sh_polarity;
    logic [N_CH-1:0]            sh_ch_en;
    logic [N_CH-1:0]            act;

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .resetb   (resetb),
        .enable   (enable),
        .prescale (prescale),
        .tick     (tick)
    );

    assign wrap    = tick && (cnt == sh_period);
    assign load    = pending && (wrap || !enable);
    assign cnt_mon = cnt;

    // Shadow config: take the live inputs only when a pending update is accepted
    always_ff @(posedge clk) begin
        if (!resetb) begin
            sh_period   <= '1;
            sh_duty     <= '0;
            sh_phase    <= '0;
            sh_polarity <= '0;
            sh_ch_en    <= '0;
        end else if (load) begin
            sh_period   <= period;
            sh_duty     <= duty;
            sh_phase    <= phase;
            sh_polarity <= polarity;
            sh_ch_en    <= ch_en;
        end
    end

    // Main counter, update bookkeeping and the registered one-clk pulses
    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt         <= '0;
            pending     <= 1'b0;
            update_ack  <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            update_ack  <= load;
            period_tick <= wrap;
            if (load) begin
                pending <= 1'b0;
            end else if (update_req) begin
                pending <= 1'b1;
            end
            if (!enable) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
        end
    end

    // Per-channel compare: shift the counter by the phase modulo period+1,
    // using one spare bit so the sum can never overflow
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] ph;
        logic [CNT_W:0]   sum;
        logic [CNT_W:0]   local_pos;

        assign ph        = (sh_phase[i] > sh_period) ? '0 : sh_phase[i];
        assign sum       = {1'b0, cnt} + {1'b0, ph};
        assign local_pos = (sum > {1'b0, sh_period})
                           ? sum - ({1'b0, sh_period} + 1'b1)
                           : sum;
        assign act[i]    = sh_ch_en[i] && (local_pos < {1'b0, sh_duty[i]});
    end

    // Registered outputs; a stopped generator parks every channel at its idle level
    always_ff @(posedge clk) begin
        if (!resetb) begin
            pwm_out <= '0;
        end else if (!enable) begin
            pwm_out <= sh_polarity;
        end else begin
            pwm_out <= act ^ sh_polarity;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: a cycle model computes the expected
// outputs with modulo arithmetic and is compared every cycle, while directed
// scenarios pin the model with hand-computed pulse counts.
module tb_pwm_multi_ch;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            resetb;
    logic            enable;
    logic [PW-1:0]   prescale;
    logic [CW-1:0]   period;
    logic [N*CW-1:0] duty;
    logic [N*CW-1:0] phase;
    logic [N-1:0]    polarity;
    logic [N-1:0]    ch_en;
    logic            update_req;
    logic            update_ack;
    logic            period_tick;
    logic [CW-1:0]   cnt_mon;
    logic [N-1:0]    pwm_out;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi_ch dut (
        .clk         (clk),
        .resetb      (resetb),
        .enable      (enable),
        .prescale    (prescale),
        .period      (period),
        .duty        (duty),
        .phase       (phase),
        .polarity    (polarity),
        .ch_en       (ch_en),
        .update_req  (update_req),
        .update_ack  (update_ack),
        .period_tick (period_tick),
        .cnt_mon     (cnt_mon),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model state
    bit           model_valid = 1'b0;
    int           m_psc, m_cnt, m_period;
    bit           m_pend;
    int           m_duty [N];
    int           m_phase[N];
    bit [N-1:0]   m_pol, m_en;
    logic [N-1:0] exp_pwm;
    bit           exp_ack, exp_tick;
    bit           m_tick, m_wrap, m_load;
    int           m_ph, m_pos;

    // Model: timer ticks every prescale+1 clocks, counter wraps modulo period+1,
    // channel i is active while (cnt+phase) mod (period+1) is below its duty
    always @(posedge clk) begin
        if (!resetb) begin
            model_valid = 1'b1;
            m_psc = 0; m_cnt = 0; m_pend = 0; m_period = 255;
            for (int c = 0; c < N; c++) begin
                m_duty[c] = 0; m_phase[c] = 0;
            end
            m_pol = '0; m_en = '0;
            exp_pwm = '0; exp_ack = 0; exp_tick = 0;
        end else begin
            m_tick = enable && (m_psc == int'(prescale));
            m_wrap = m_tick && (m_cnt == m_period);
            m_load = m_pend && (m_wrap || !enable);
            for (int c = 0; c < N; c++) begin
                if (!enable) begin
                    exp_pwm[c] = m_pol[c];
                end else begin
                    m_ph  = (m_phase[c] > m_period) ? 0 : m_phase[c];
                    m_pos = (m_cnt + m_ph) % (m_period + 1);
                    exp_pwm[c] = (m_en[c] && (m_pos < m_duty[c])) ^ m_pol[c];
                end
            end
            exp_tick = m_wrap;
            exp_ack  = m_load;
            if (!enable) begin
                m_psc = 0; m_cnt = 0;
            end else if (m_tick) begin
                m_psc = 0;
                m_cnt = m_wrap ? 0 : m_cnt + 1;
            end else begin
                m_psc = m_psc + 1;
            end
            if (m_load) begin
                m_period = int'(period);
                for (int c = 0; c < N; c++) begin
                    m_duty[c]  = int'(duty[c*CW +: CW]);
                    m_phase[c] = int'(phase[c*CW +: CW]);
                end
                m_pol = polarity;
                m_en  = ch_en;
                m_pend = 0;
            end else if (update_req) begin
                m_pend = 1;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("pwm_out",     32'(pwm_out),     32'(exp_pwm));
            checkOutput("update_ack",  32'(update_ack),  32'(exp_ack));
            checkOutput("period_tick", 32'(period_tick), 32'(exp_tick));
            checkOutput("cnt_mon",     32'(cnt_mon),     32'(m_cnt));
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input int per, input int psc,
                                 input logic [N*CW-1:0] dty, input logic [N*CW-1:0] phs,
                                 input logic [N-1:0] pol, input logic [N-1:0] en);
        period   = per[CW-1:0];
        prescale = psc[PW-1:0];
        duty     = dty;
        phase    = phs;
        polarity = pol;
        ch_en    = en;
    endtask

    task automatic pulseUpdate();
        update_req = 1'b1;
        cycles(1);
        update_req = 1'b0;
    endtask

    task automatic waitAck(input int limit, output int highs0, output int ack_cnt, output bit got);
        highs0 = 0; ack_cnt = 0; got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            highs0 += int'(pwm_out[0]);
            if (update_ack) begin
                got = 1'b1;
                ack_cnt = int'(cnt_mon);
            end
        end
        if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic doUpdate();
        int  h, c;
        bit  g;
        pulseUpdate();
        waitAck(1000, h, c, g);
    endtask

    task automatic waitCnt(input int val, input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (int'(cnt_mon) == val) found = 1'b1;
        end
        if (!found) checkOutput("cnt_timeout", 32'd0, 32'd1);
    endtask

    // Skip one sample, then accumulate n samples of the outputs
    task automatic observe(input int n, output int h0, output int h1, output int ticks,
                           output int acks, output int comp, output int chg);
        logic [CW-1:0] prev;
        h0 = 0; h1 = 0; ticks = 0; acks = 0; comp = 0; chg = 0;
        @(negedge clk);
        prev = cnt_mon;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h0    += int'(pwm_out[0]);
            h1    += int'(pwm_out[1]);
            ticks += int'(period_tick);
            acks  += int'(update_ack);
            comp  += int'(pwm_out[1] != pwm_out[0]);
            chg   += int'(cnt_mon != prev);
            prev  = cnt_mon;
        end
    endtask

    task automatic randomizeCfg();
        int per;
        per = int'($urandom_range(1, 20));
        period = per[CW-1:0];
        for (int c = 0; c < N; c++) begin
            duty[c*CW +: CW]  = CW'($urandom_range(0, per + 2));
            phase[c*CW +: CW] = CW'($urandom_range(0, per + 3));
        end
        polarity = N'($urandom);
        ch_en    = N'($urandom);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int h0, h1, ticks, acks, comp, chg, ack_cnt;
        bit got;

        resetb = 1'b0; enable = 1'b0; update_req = 1'b0;
        applyStimulus(0, 0, '0, '0, '0, '0);
        cycles(3);

        // Reset state
        @(negedge clk);
        checkOutput("rst_pwm",  32'(pwm_out),     32'd0);
        checkOutput("rst_ack",  32'(update_ack),  32'd0);
        checkOutput("rst_tick", 32'(period_tick), 32'd0);
        checkOutput("rst_cnt",  32'(cnt_mon),     32'd0);
        resetb = 1'b1;

        // Basic: period 9, ch0 duty 3
        $display("[TB] basic duty 3/10");
        applyStimulus(9, 0, {8'd0, 8'd0, 8'd0, 8'd3}, '0, 4'b0000, 4'b0001);
        doUpdate();
        cycles(1);
        enable = 1'b1;
        observe(30, h0, h1, ticks, acks, comp, chg);
        checkOutput("basic_highs", 32'(h0),    32'd9);
        checkOutput("basic_ticks", 32'(ticks), 32'd3);
        checkOutput("basic_acks",  32'(acks),  32'd0);

        // Mid-period update 3 -> 7 issued at cnt=4
        $display("[TB] mid-period duty update");
        waitCnt(4, 50);
        duty[7:0] = 8'd7;
        pulseUpdate();
        waitAck(100, h0, ack_cnt, got);
        checkOutput("mid_old_highs", 32'(h0),      32'd0);
        checkOutput("mid_ack_cnt",   32'(ack_cnt), 32'd0);
        observe(30, h0, h1, ticks, acks, comp, chg);
        checkOutput("mid_new_highs", 32'(h0),   32'd21);
        checkOutput("mid_acks",      32'(acks), 32'd0);

        // Boundary duties: 0 and period+1
        $display("[TB] boundary duty");
        applyStimulus(9, 0, {8'd0, 8'd0, 8'd10, 8'd0}, '0, 4'b0000, 4'b0011);
        doUpdate();
        observe(20, h0, h1, ticks, acks, comp, chg);
        checkOutput("bnd_ch0_highs", 32'(h0), 32'd0);
        checkOutput("bnd_ch1_highs", 32'(h1), 32'd20);

        // Phase offset: complementary channels
        $display("[TB] phase offset");
        applyStimulus(9, 0, {8'd0, 8'd0, 8'd5, 8'd5}, 32'h0000_0500, 4'b0000, 4'b0011);
        doUpdate();
        observe(20, h0, h1, ticks, acks, comp, chg);
        checkOutput("phase_complement", 32'(comp), 32'd20);

        // Disabled state, then prescaler 3
        $display("[TB] disable and prescaler");
        cycles(1);
        enable = 1'b0;
        cycles(2);
        @(negedge clk);
        checkOutput("dis_pwm", 32'(pwm_out), 32'd0);
        checkOutput("dis_cnt", 32'(cnt_mon), 32'd0);
        prescale = 8'd3;
        enable   = 1'b1;
        observe(80, h0, h1, ticks, acks, comp, chg);
        checkOutput("psc_cnt_changes", 32'(chg),   32'd20);
        checkOutput("psc_ticks",       32'(ticks), 32'd2);

        // Polarity inversion, loaded while stopped
        $display("[TB] polarity");
        enable = 1'b0;
        cycles(1);
        applyStimulus(9, 0, {8'd0, 8'd0, 8'd5, 8'd2}, 32'h0000_0500, 4'b0001, 4'b0011);
        doUpdate();
        @(negedge clk);
        checkOutput("pol_idle_pwm", 32'(pwm_out), 32'd1);
        checkOutput("pol_idle_cnt", 32'(cnt_mon), 32'd0);
        enable = 1'b1;
        observe(40, h0, h1, ticks, acks, comp, chg);
        checkOutput("pol_ch0_highs", 32'(h0), 32'd32);
        checkOutput("pol_ch1_highs", 32'(h1), 32'd20);

        // Reset mid-period with an update pending
        $display("[TB] reset mid-run");
        waitCnt(3, 50);
        duty[7:0] = 8'd9;
        update_req = 1'b1;
        cycles(1);
        update_req = 1'b0;
        resetb = 1'b0;
        cycles(1);
        resetb = 1'b1;
        @(negedge clk);
        checkOutput("mrst_pwm", 32'(pwm_out), 32'd0);
        checkOutput("mrst_cnt", 32'(cnt_mon), 32'd0);
        observe(20, h0, h1, ticks, acks, comp, chg);
        checkOutput("mrst_acks",  32'(acks), 32'd0);
        checkOutput("mrst_highs", 32'(h0 + h1), 32'd0);

        // Randomized traffic against the model
        $display("[TB] random phase");
        enable = 1'b0;
        prescale = 8'd0;
        randomizeCfg();
        pulseUpdate();
        cycles(3);
        for (int it = 0; it < 60; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                resetb = 1'b0;
                cycles(2);
                resetb = 1'b1;
                enable = 1'b0;
                randomizeCfg();
                pulseUpdate();
            end else if (r < 3) begin
                if (enable) begin
                    enable = 1'b0;
                    cycles(1);
                    prescale = PW'($urandom_range(0, 2));
                end else begin
                    enable = 1'b1;
                end
            end else begin
                randomizeCfg();
                pulseUpdate();
            end
            cycles(int'($urandom_range(3, 40)));
        end

        cycles(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
